// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// funct3 op encodings, FSM state encoding and operand-signedness helpers.
package muldiv_seq_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Divide and remainder ops all live in the upper half of the funct3 space.
  function automatic logic op_is_div(input logic [2:0] op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  // rs1 is treated as signed for MUL/MULH/MULHSU/DIV/REM.
  function automatic logic op_rs1_signed(input logic [2:0] op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is treated as signed for MUL/MULH/DIV/REM.
  function automatic logic op_rs2_signed(input logic [2:0] op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq_adder.sv
// Plain ripple-style adder with carry-in; shared by the multiply accumulate
// and the divide trial subtract.
module muldiv_seq_adder #(
  parameter int WIDTH = 33
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage. Runs a
// shift-add multiply or a restoring divide one bit per cycle, stalls the
// pipeline while busy and presents the result with a one-cycle done pulse.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start_EX,
  input  logic             i_flush_EX,
  input  logic [2:0]       i_md_op_EX,
  input  logic [WIDTH-1:0] i_rd1_EX,
  input  logic [WIDTH-1:0] i_rd2_EX,
  output logic             o_busy_EX,
  output logic             o_stall_EX,
  output logic             o_done_EX,
  output logic [WIDTH-1:0] o_md_result_EX
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [CW-1:0]      count;
  logic [2:0]         op_r;
  // Multiply: {product_hi, product_lo}; divide: {remainder, quotient}.
  // Between IDLE and PREP the low half holds the raw rs1 operand.
  logic [2*WIDTH-1:0] acc;
  // Multiplicand or divisor magnitude; raw rs2 between IDLE and PREP.
  logic [WIDTH-1:0]   opd;
  logic               neg1_r;
  logic               neg2_r;

  logic               is_div;
  logic               neg1;
  logic               neg2;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic               div_by_zero;
  logic               div_ovf;
  logic               special;
  logic [WIDTH-1:0]   special_result;

  logic               add_cin;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic [WIDTH:0]     add_sum;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_result;

  assign o_busy_EX  = (state == ST_PREP) || (state == ST_CALC) || (state == ST_FIX);
  assign o_stall_EX = o_busy_EX || (i_start_EX && (state == ST_IDLE));

  // Operand sign/magnitude decode of the raw latched operands (used in PREP).
  assign is_div      = op_is_div(op_r);
  assign neg1        = op_rs1_signed(op_r) && acc[WIDTH-1];
  assign neg2        = op_rs2_signed(op_r) && opd[WIDTH-1];
  assign mag1        = neg1 ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign mag2        = neg2 ? -opd : opd;
  assign div_by_zero = (opd == '0);
  assign div_ovf     = ((op_r == MD_DIV) || (op_r == MD_REM)) &&
                       (acc[WIDTH-1:0] == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (opd == '1);
  assign special     = is_div && (div_by_zero || div_ovf);

  // Results of the divide corner cases that bypass the iteration.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    special_result = '0;
    if (div_by_zero) begin
      special_result = op_r[1] ? acc[WIDTH-1:0] : '1;
    end else if (div_ovf) begin
      special_result = op_r[1] ? '0 : acc[WIDTH-1:0];
    end
  end

  // Adder operand steering: accumulate for multiply, trial subtract for divide.
  always_comb begin
    add_cin = 1'b0;
    add_a   = {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_b   = {1'b0, {WIDTH{acc[0]}} & opd};
    if (is_div) begin
      // Shifted remainder minus divisor; sum MSB set means it borrowed.
      add_cin = 1'b1;
      add_a   = acc[2*WIDTH-1:WIDTH-1];
      add_b   = ~{1'b0, opd};
    end
  end

  muldiv_seq_adder #(
    .WIDTH (WIDTH + 1)
  ) u_adder (
    .cin (add_cin),
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  // Sign correction and result selection for the FIX state.
  always_comb begin
    prod_fix = (neg1_r ^ neg2_r) ? -acc : acc;
    quot_fix = (neg1_r ^ neg2_r) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg1_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (op_r)
      MD_MUL:                       fix_result = prod_fix[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              fix_result = quot_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  // Sequencer FSM, iteration counter and done pulse; flush wins everywhere.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      o_done_EX <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      o_done_EX <= 1'b0;
      if (i_flush_EX) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (i_start_EX) state <= ST_PREP;
          ST_PREP: begin
            count <= CW'(WIDTH - 1);
            if (special) begin
              state     <= ST_DONE;
              o_done_EX <= 1'b1;
            end else begin
              state <= ST_CALC;
            end
          end
          ST_CALC: begin
            if (count == '0) state <= ST_FIX;
            else             count <= count - CW'(1);
          end
          ST_FIX: begin
            state     <= ST_DONE;
            o_done_EX <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Datapath: operand capture, magnitude prep, per-bit iteration and result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: datapath registers are reset too, so a reset mid-operation
      // leaves no stale operands or result visible.
      op_r           <= '0;
      acc            <= '0;
      opd            <= '0;
      neg1_r         <= 1'b0;
      neg2_r         <= 1'b0;
      o_md_result_EX <= '0;
    end else if (!i_flush_EX) begin
      case (state)
        ST_IDLE: begin
          if (i_start_EX) begin
            op_r <= i_md_op_EX;
            acc  <= {{WIDTH{1'b0}}, i_rd1_EX};
            opd  <= i_rd2_EX;
          end
        end
        ST_PREP: begin
          neg1_r <= neg1;
          neg2_r <= neg2;
          if (special) begin
            o_md_result_EX <= special_result;
          end else if (is_div) begin
            acc <= {{WIDTH{1'b0}}, mag1};
            opd <= mag2;
          end else begin
            acc <= {{WIDTH{1'b0}}, mag2};
            opd <= mag1;
          end
        end
        ST_CALC: begin
          if (is_div) begin
            if (!add_sum[WIDTH]) acc <= {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                 acc <= {acc[2*WIDTH-2:0], 1'b0};
          end else begin
            acc <= {add_sum, acc[WIDTH-1:1]};
          end
        end
        ST_FIX: o_md_result_EX <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases, randomized ops against
// an arithmetic reference model, back-to-back, ignored starts, flush and
// asynchronous reset mid-operation.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  md_op;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start_EX     (start),
    .i_flush_EX     (flush),
    .i_md_op_EX     (md_op),
    .i_rd1_EX       (rd1),
    .i_rd2_EX       (rd2),
    .o_busy_EX      (busy),
    .o_stall_EX     (stall),
    .o_done_EX      (done),
    .o_md_result_EX (result)
  );

  // Directed cases: op, rs1, rs2, expected result, expected latency.
  logic [2:0]  d_op  [12] = '{MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
                              MD_DIV, MD_REM, MD_DIVU, MD_REMU,
                              MD_DIV, MD_REM, MD_DIV, MD_REM};
  logic [31:0] d_a   [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                              32'h00012345, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b   [12] = '{32'd6, 32'h80000000, 32'd2, 32'd2,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_exp [12] = '{32'd42, 32'h40000000, 32'hFFFFFFFF, 32'h00000001,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                              32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
  int          d_lat [12] = '{35, 35, 35, 35, 35, 35, 35, 35, 2, 2, 2, 2};

  // Reference model: RV32M semantics from plain 64-bit / int arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    int          ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      MD_MUL:    begin p = za * zb; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * zb; return p[63:32]; end
      MD_MULHU:  begin p = za * zb; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      MD_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return ia % ib;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU} && b == 0) return 2;
    if (op inside {MD_DIV, MD_REM} && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    return 35;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op starting at the next falling edge; report result, cycles
  // from the start sample to done (-1 on timeout) and whether stall was high
  // from the start cycle up to, and low on, the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit stall_ok);
    @(negedge clk);
    md_op = op;
    rd1   = a;
    rd2   = b;
    start = 1'b1;
    #1 stall_ok = (stall === 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    rd1 = $urandom;
    rd2 = $urandom;
    lat = -1;
    res = 'x;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc;
        res = result;
        if (stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (stall !== 1'b0)   begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int          lat;
    bit          sok;
    for (int i = 0; i < 12; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], res, lat, sok);
      n_cmp++;
      if (res !== d_exp[i]) begin
        n_err++;
        $display("FAIL directed%0d_result op=%0d a=%h b=%h: got %h expected %h",
                 i, d_op[i], d_a[i], d_b[i], res, d_exp[i]);
      end
      n_cmp++;
      if (lat != d_lat[i]) begin
        n_err++;
        $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, d_lat[i]);
      end
      n_cmp++;
      if (sok !== 1'b1) begin
        n_err++;
        $display("FAIL directed%0d_stall: got %b expected 1", i, sok);
      end
      last_exp = d_exp[i];
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, exp, res;
    int          lat, exp_lat;
    bit          sok;
    for (int i = 0; i < 40; i++) begin
      op      = 3'($urandom_range(0, 7));
      a       = pick_operand();
      b       = pick_operand();
      exp     = ref_md(op, a, b);
      exp_lat = ref_latency(op, a, b);
      run_op(op, a, b, res, lat, sok);
      n_cmp++;
      if (res !== exp) begin
        n_err++;
        $display("FAIL random%0d_result op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, exp);
      end
      n_cmp++;
      if (lat != exp_lat) begin
        n_err++;
        $display("FAIL random%0d_latency op=%0d a=%h b=%h: got %0d expected %0d",
                 i, op, a, b, lat, exp_lat);
      end
      last_exp = exp;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res1, res2, exp1, exp2, a1, b1, a2, b2;
    int          lat1, lat2;
    bit          sok1, sok2;
    a1 = $urandom; b1 = $urandom_range(1, 5000);
    a2 = $urandom; b2 = $urandom;
    exp1 = ref_md(MD_REMU, a1, b1);
    exp2 = ref_md(MD_MULHU, a2, b2) | 32'd0;
    run_op(MD_REMU, a1, b1, res1, lat1, sok1);
    run_op(MD_MULHU, a2, b2, res2, lat2, sok2);
    n_cmp++; if (res1 !== exp1) begin n_err++; $display("FAIL b2b_first: got %h expected %h", res1, exp1); end
    n_cmp++; if (res2 !== exp2) begin n_err++; $display("FAIL b2b_second: got %h expected %h", res2, exp2); end
    n_cmp++; if (lat2 != 35)    begin n_err++; $display("FAIL b2b_latency: got %0d expected 35", lat2); end
    n_cmp++; if (sok2 !== 1'b1) begin n_err++; $display("FAIL b2b_stall: got %b expected 1", sok2); end
    last_exp = exp2;
  endtask

  task automatic test_start_ignored();
    logic [31:0] a, b, exp, res;
    int          lat;
    a   = $urandom | 32'h1;
    b   = $urandom | 32'h1;
    exp = ref_md(MD_MUL, a, b);
    @(negedge clk);
    md_op = MD_MUL; rd1 = a; rd2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    res = 'x;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc;
        res = result;
        break;
      end
      start = (cyc == 5 || cyc == 12 || cyc == 20);
      md_op = 3'($urandom_range(0, 7));
      rd1   = $urandom;
      rd2   = $urandom;
    end
    start = 1'b0;
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL ignored_start_result: got %h expected %h", res, exp); end
    n_cmp++; if (lat != 35)   begin n_err++; $display("FAIL ignored_start_latency: got %0d expected 35", lat); end
    last_exp = exp;
  endtask

  task automatic test_flush();
    bit saw_done;
    @(negedge clk);
    md_op = MD_DIV; rd1 = $urandom; rd2 = $urandom_range(1, 1000); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL flush_done_now: got %b expected 0", done); end
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0)  begin n_err++; $display("FAIL flush_no_done: got %b expected 0", saw_done); end
    n_cmp++; if (result !== last_exp) begin n_err++; $display("FAIL flush_result_held: got %h expected %h", result, last_exp); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b, exp, res;
    int          lat;
    bit          sok;
    @(negedge clk);
    md_op = MD_DIVU; rd1 = $urandom; rd2 = $urandom_range(1, 99); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 15; cyc++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_cmp++; if (stall !== 1'b0)   begin n_err++; $display("FAIL rstmid_stall: got %b expected 0", stall); end
    n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL rstmid_done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL rstmid_result: got %h expected 0", result); end
    @(negedge clk);
    rst = 1'b0;
    a   = $urandom;
    b   = $urandom;
    exp = ref_md(MD_MULH, a, b);
    run_op(MD_MULH, a, b, res, lat, sok);
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL rstmid_recover_result: got %h expected %h", res, exp); end
    n_cmp++; if (lat != 35)   begin n_err++; $display("FAIL rstmid_recover_latency: got %0d expected 35", lat); end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    md_op = '0;
    rd1   = '0;
    rd2   = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
